// File: rtl/ifu_fq_pkg.sv
// Shared types for the instruction fetch unit: instruction-bus request/response,
// fetch-queue entries, fetch FSM states and a PC alignment helper.
package ifu_fq_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic            we;
        logic [1:0]      size;
        logic [XLEN-1:0] wdata;
    } ibus_req_t;

    typedef struct packed {
        logic            data_ok;
        logic            err;
        logic [XLEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_DROP = 2'd2
    } ifu_state_t;

    // Instructions are word aligned; the two low target bits carry no meaning.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Circular fetch queue of {pc, instr} entries with push, pop and a flush that
// overrides both. The head reads as zero while the queue is empty.
module ifu_fifo
    import ifu_fq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  fq_entry_t        i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output fq_entry_t        o_head,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop  && !i_flush && !o_empty;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding ibus request
// at a time and buffers returned instructions for decode; redirects flush it all.
module ifu_fq
    import ifu_fq_pkg::*;
#(
    parameter  logic [63:0] RESET_PC = 64'h8000_0000,
    parameter  int          DEPTH    = 4,
    localparam int          PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [63:0]      pc_target,
    input  ibus_resp_t       iresp,
    output ibus_req_t        ireq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   fq_count,
    output ifu_state_t       dbg_state
);

    // Handshakes: decode takes the head in any cycle where out_valid && out_ready
    // are both high, except a redirect cycle, where the head is void and the queue
    // is flushed. A bus request is held (valid and addr stable) until data_ok.

    ifu_state_t   r_state;
    logic [63:0]  r_pc;
    logic [63:0]  r_req_pc;

    logic [63:0]      w_target;
    logic [63:0]      w_next_pc;
    logic             w_pending_push;
    logic             w_can_issue;
    logic             w_pop;
    logic [PTR_W+1:0] w_occupancy;
    logic [PTR_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    fq_entry_t        w_head;
    fq_entry_t        w_push_entry;
    logic             w_unused_bits;

    assign w_target       = align_pc(pc_target);
    assign w_next_pc      = r_req_pc + 64'd4;
    assign w_pending_push = (r_state == IFU_REQ) && iresp.data_ok && !redirect_valid;

    // Counting the push landing this cycle keeps a fresh request from ever
    // returning into a full queue.
    assign w_occupancy = {1'b0, w_count} + (PTR_W+2)'(w_pending_push);
    assign w_can_issue = fetch_en && !redirect_valid
                         && (w_occupancy < (PTR_W+2)'(DEPTH));
    assign w_pop       = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IFU_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            case (r_state)
                IFU_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end else if (w_can_issue) begin
                        r_state  <= IFU_REQ;
                        r_req_pc <= r_pc;
                    end
                end
                IFU_REQ: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= iresp.data_ok ? IFU_IDLE : IFU_DROP;
                    end else if (iresp.data_ok) begin
                        if (w_can_issue) begin
                            r_req_pc <= w_next_pc;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= IFU_IDLE;
                        end
                    end
                end
                IFU_DROP: begin
                    // The bus still owes us a beat; swallow it, keep the newest target.
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    if (iresp.data_ok) begin
                        r_state <= IFU_IDLE;
                    end
                end
                default: begin
                    r_state <= IFU_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ireq       = '0;
        ireq.valid = (r_state != IFU_IDLE);
        ireq.addr  = r_req_pc;
    end

    assign w_push_entry = '{pc: r_req_pc, instr: iresp.data[31:0]};

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_pending_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign fq_count  = w_count;
    assign dbg_state = r_state;

    assign w_unused_bits = ^{iresp.err, iresp.data[63:32], w_full};

endmodule

// File: tb/tb_ifu_fq.sv
// Bench for ifu_fq: a bus memory with controllable latency, a transaction-level
// fetch-stream model with an expected queue, directed cases and a random phase.
module tb_ifu_fq;
    import ifu_fq_pkg::*;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          DEPTH    = 4;
    localparam int          PTR_W    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_en;
    logic             redirect_valid;
    logic [63:0]      pc_target;
    ibus_resp_t       iresp;
    ibus_req_t        ireq;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   fq_count;
    ifu_state_t       dbg_state;

    always #5 clk = ~clk;

    ifu_fq #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .pc_target      (pc_target),
        .iresp          (iresp),
        .ireq           (ireq),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fq_count       (fq_count),
        .dbg_state      (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory side
    int lat;
    int lat_min = 0;
    int lat_max = 0;
    bit mem_busy = 1'b0;
    bit hold_ok  = 1'b0;

    // Reference model: expected fetch-queue contents and request stream
    logic [95:0] exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] m_next_req;
    logic [63:0] m_req_addr;
    bit          m_out;
    bit          m_keep;
    logic        p_en;
    logic        p_redir;
    int          p_occ;
    int          n_starts;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_cycle();
        int occ;
        bit new_start;
        bit push_now;
        occ       = exp_q.size();
        new_start = ireq.valid && !m_out;
        if (ireq.valid) begin
            check("req_side_zero", 64'(|{ireq.we, ireq.size, ireq.wdata}), 64'd0);
        end
        if (m_out) begin
            check("req_hold_valid", 64'(ireq.valid), 64'd1);
            check("req_hold_addr", ireq.addr, m_req_addr);
        end
        if (new_start) begin
            check("req_addr", ireq.addr, m_next_req);
            check("issue_allowed", 64'({p_en, p_redir, (p_occ < DEPTH)}), 64'b101);
            req_log.push_back(ireq.addr);
            n_starts++;
            m_out      = 1'b1;
            m_keep     = 1'b1;
            m_req_addr = ireq.addr;
            m_next_req = ireq.addr + 64'd4;
        end
        check("fq_count", 64'(fq_count), 64'(occ));
        check("out_valid", 64'(out_valid), 64'(occ != 0));
        if (occ != 0) begin
            check("out_pc", out_pc, exp_q[0][95:32]);
            check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
        end
        push_now = m_out && m_keep && iresp.data_ok && !redirect_valid;
        p_occ    = occ + int'(push_now);
        if (redirect_valid) begin
            exp_q.delete();
            m_next_req = {pc_target[63:2], 2'b00};
            if (m_out) begin
                if (iresp.data_ok) m_out = 1'b0;
                else               m_keep = 1'b0;
            end
        end else begin
            if (out_ready && occ != 0) void'(exp_q.pop_front());
            if (m_out && iresp.data_ok) begin
                if (m_keep) exp_q.push_back({m_req_addr, instr_of(m_req_addr)});
                m_out = 1'b0;
            end
        end
        p_en    = fetch_en;
        p_redir = redirect_valid;
    endtask

    task automatic step(input logic en, input logic rdy, input logic redir, input logic [63:0] tgt);
        @(posedge clk);
        #1;
        fetch_en       = en;
        out_ready      = rdy;
        redirect_valid = redir;
        pc_target      = tgt;
        iresp          = '0;
        iresp.err      = 1'($urandom);
        iresp.data     = {$urandom, $urandom};
        if (ireq.valid) begin
            if (!mem_busy) begin
                lat      = $urandom_range(lat_max, lat_min);
                mem_busy = 1'b1;
            end
            if (!hold_ok) begin
                if (lat == 0) begin
                    iresp.data_ok    = 1'b1;
                    iresp.data[31:0] = instr_of(ireq.addr);
                    mem_busy         = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
        @(negedge clk);
        model_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        pc_target      = '0;
        iresp          = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_busy = 1'b0;
        hold_ok  = 1'b0;
        @(negedge clk);
        check("rst_req_valid", 64'(ireq.valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_fq_count", 64'(fq_count), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IFU_IDLE));
        exp_q.delete();
        req_log.delete();
        m_out      = 1'b0;
        m_keep     = 1'b0;
        m_next_req = RESET_PC;
        p_en       = 1'b0;
        p_redir    = 1'b0;
        p_occ      = 0;
        n_starts   = 0;
    endtask

    initial begin
        int guard;
        int n0;
        int hits;
        logic r;
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        pc_target = '0; iresp = '0;

        // Fill with single-cycle memory latency, decode stalled
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 64'd0);
        check("fill_count", 64'(fq_count), 64'd4);
        check("fill_req_idle", 64'(ireq.valid), 64'd0);
        check("fill_n_reqs", 64'(req_log.size()), 64'd4);
        check("fill_last_addr", req_log[3], 64'h8000_000C);

        // One pop frees exactly one slot
        n0 = n_starts;
        step(1'b1, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 64'd0);
        check("refill_n_reqs", 64'(n_starts - n0), 64'd1);
        check("refill_addr", req_log[req_log.size()-1], 64'h8000_0010);
        check("refill_count", 64'(fq_count), 64'd4);

        // Redirect while a slow request is outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        guard = 0;
        while (!(ireq.valid && ireq.addr == 64'h8000_0008) && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        check("drop_reach", 64'(guard < 50), 64'd1);
        step(1'b1, 1'b0, 1'b1, 64'h8000_0100);
        guard = 0;
        while (!out_valid && guard < 50) begin
            step(1'b1, 1'b0, 1'b0, 64'd0); guard++;
        end
        check("drop_first_pc", out_pc, 64'h8000_0100);

        // Redirect together with data_ok and pop on a two-entry queue
        do_reset();
        lat_min = 0; lat_max = 0;
        guard = 0;
        while (fq_count != 1 && guard < 50) begin
            step(1'b1, 1'b0, 1'b0, 64'd0); guard++;
        end
        hold_ok = 1'b1;
        step(1'b1, 1'b0, 1'b0, 64'd0);
        hold_ok = 1'b0;
        step(1'b1, 1'b1, 1'b1, 64'h8000_0400);
        check("coinc_pre_count", 64'(fq_count), 64'd2);
        check("coinc_data_ok", 64'(iresp.data_ok), 64'd1);
        step(1'b0, 1'b0, 1'b0, 64'd0);
        check("coinc_flush", 64'(fq_count), 64'd0);
        n0 = req_log.size();
        guard = 0;
        while (req_log.size() == n0 && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        check("coinc_next_req", req_log[req_log.size()-1], 64'h8000_0400);

        // Two redirects during one DROP: only the newest target is fetched
        do_reset();
        guard = 0;
        while (!ireq.valid && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        hold_ok = 1'b1;
        step(1'b1, 1'b1, 1'b1, 64'h200);
        step(1'b1, 1'b1, 1'b1, 64'h300);
        step(1'b1, 1'b1, 1'b0, 64'd0);
        hold_ok = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 64'd0);
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 64'h200) hits++;
        check("dbl_redir_no_200", 64'(hits), 64'd0);
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 64'h300) hits++;
        check("dbl_redir_300", 64'(hits), 64'd1);

        // Unaligned target, then PC wrap at the top of the address space
        do_reset();
        step(1'b0, 1'b0, 1'b1, 64'h8000_0103);
        guard = 0;
        while (req_log.size() == 0 && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        check("align_addr", req_log[0], 64'h8000_0100);
        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        n0 = req_log.size();
        guard = 0;
        while (req_log.size() < n0 + 2 && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        check("wrap_first", req_log[n0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_second", req_log[n0+1], 64'd0);

        // Reset in the middle of a request
        lat_min = 3; lat_max = 3;
        guard = 0;
        while (!ireq.valid && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        do_reset();
        guard = 0;
        while (req_log.size() == 0 && guard < 50) begin
            step(1'b1, 1'b1, 1'b0, 64'd0); guard++;
        end
        check("post_rst_addr", req_log[0], RESET_PC);

        // Random traffic
        lat_min = 0; lat_max = 3;
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = !r && ($urandom_range(19, 0) == 0);
            step(1'($urandom_range(9, 0) < 8), 1'($urandom_range(9, 0) < 6), r,
                 ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0))
                                             : {$urandom, $urandom});
        end
        check("rand_activity", 64'(n_starts > 100), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
